// File: rtl/snake_pkg.sv
// Shared board geometry, coordinate types and the food placer state
// encoding for the snake game.
package snake_pkg;

  localparam int GRID_BITS  = 3;
  localparam int GRID_CELLS = 64;

  typedef logic [GRID_BITS-1:0] coord_t;

  // A board cell. y is the upper field, so the packed value is the
  // row-major linear index of the cell.
  typedef struct packed {
    coord_t y;
    coord_t x;
  } cell_t;

  typedef enum logic [1:0] {
    FP_IDLE = 2'd0,
    FP_RAND = 2'd1,
    FP_SCAN = 2'd2
  } fp_state_t;

  // Row-major successor: step x, carry into y at the end of a row,
  // and wrap from the last cell back to the first.
  function automatic cell_t next_cell(cell_t c);
    cell_t n;
    n.x = c.x + coord_t'(1);
    n.y = (c.x == '1) ? c.y + coord_t'(1) : c.y;
    return n;
  endfunction

endpackage

// File: rtl/food_placer_if.sv
// Signal bundle between the food placer and its environment (random number
// generator, snake occupancy lookup and game control).
//
// Handshake: place_req is a single-cycle request that is taken only while
// busy is low and is dropped otherwise. The search ends with exactly one
// single-cycle pulse, either done (food_x/food_y valid, food_valid set) or
// board_full (no free cell, food_valid cleared). occ_hit is a same-cycle
// combinational answer for the cell currently on probe_x/probe_y.
interface food_placer_if;
  import snake_pkg::*;

  logic      place_req;
  logic      food_clr;
  coord_t    rng_x;
  coord_t    rng_y;
  coord_t    probe_x;
  coord_t    probe_y;
  logic      occ_hit;
  coord_t    food_x;
  coord_t    food_y;
  logic      food_valid;
  logic      busy;
  logic      done;
  logic      board_full;
  fp_state_t state_dbg;

  modport master (
    output place_req, food_clr, rng_x, rng_y, occ_hit,
    input  probe_x, probe_y, food_x, food_y, food_valid, busy, done,
           board_full, state_dbg
  );

  modport slave (
    input  place_req, food_clr, rng_x, rng_y, occ_hit,
    output probe_x, probe_y, food_x, food_y, food_valid, busy, done,
           board_full, state_dbg
  );

endinterface

// File: rtl/food_placer.sv
// Finds a free board cell for new food: first a bounded number of random
// candidates, then a linear sweep of the remaining cells, reporting either
// the placed cell or that the board is full.
module food_placer
  import snake_pkg::*;
#(
  parameter int MAX_TRIES = 16
) (
  input  logic          clk,
  input  logic          reset,
  food_placer_if.slave  bus
);

  localparam logic [5:0] TRY_LAST  = 6'(MAX_TRIES - 1);
  localparam logic [5:0] SCAN_LAST = 6'(GRID_CELLS - 1);

  fp_state_t  state_q, state_d;
  cell_t      cand_q, cand_d;
  logic [5:0] try_q, try_d;
  logic [5:0] scan_q, scan_d;
  cell_t      food_q, food_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       full_q, full_d;

  // State and datapath registers; reset aborts any search without a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FP_IDLE;
      cand_q  <= '0;
      try_q   <= '0;
      scan_q  <= '0;
      food_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      try_q   <= try_d;
      scan_q  <= scan_d;
      food_q  <= food_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  // Next-state logic: probe the current candidate, accept it when free,
  // otherwise draw another random cell or step linearly through the board.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    try_d   = try_q;
    scan_d  = scan_q;
    food_d  = food_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    full_d  = 1'b0;

    // Eaten food invalidates the old cell; a placement finishing in the
    // same cycle overrides this below with the new cell.
    if (bus.food_clr) begin
      valid_d = 1'b0;
    end

    case (state_q)
      FP_IDLE: begin
        if (bus.place_req) begin
          cand_d  = cell_t'({bus.rng_y, bus.rng_x});
          try_d   = '0;
          state_d = FP_RAND;
        end
      end

      FP_RAND: begin
        if (!bus.occ_hit) begin
          food_d  = cand_q;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = FP_IDLE;
        end else if (try_q == TRY_LAST) begin
          cand_d  = next_cell(cand_q);
          scan_d  = 6'd1;
          state_d = FP_SCAN;
        end else begin
          cand_d  = cell_t'({bus.rng_y, bus.rng_x});
          try_d   = try_q + 6'd1;
        end
      end

      FP_SCAN: begin
        if (!bus.occ_hit) begin
          food_d  = cand_q;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = FP_IDLE;
        end else if (scan_q == SCAN_LAST) begin
          // Every cell has now been probed once in this sweep.
          valid_d = 1'b0;
          full_d  = 1'b1;
          state_d = FP_IDLE;
        end else begin
          cand_d  = next_cell(cand_q);
          scan_d  = scan_q + 6'd1;
        end
      end

      default: begin
        state_d = FP_IDLE;
      end
    endcase
  end

  assign bus.probe_x    = cand_q.x;
  assign bus.probe_y    = cand_q.y;
  assign bus.food_x     = food_q.x;
  assign bus.food_y     = food_q.y;
  assign bus.food_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.board_full = full_q;
  assign bus.busy       = (state_q != FP_IDLE);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: a behavioural board/search model predicts the
// placed cell, the result type and its latency from the random samples the
// bench feeds in and a board occupancy map that also answers the probes.
module tb_food_placer;
  import snake_pkg::*;

  localparam int MT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  food_placer_if bus();

  food_placer #(.MAX_TRIES(MT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Board occupancy, indexed y*8+x; acts as the snake body lookup.
  bit occ [64];
  assign bus.occ_hit = occ[{bus.probe_y, bus.probe_x}];

  int total = 0;
  int bad   = 0;

  // Planned random samples for the first MT cycles of a request.
  int rx [MT];
  int ry [MT];

  // Model of the visible food registers.
  int exp_fx    = 0;
  int exp_fy    = 0;
  bit exp_valid = 1'b0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cell_of(int x, int y);
    return y * 8 + x;
  endfunction

  // Search outcome from the rules: the k-th random sample is probe k;
  // after MT busy samples, sweep row-major from the last random cell.
  task automatic predict(output int p, output int cx, output int cy,
                         output bit full);
    int x;
    int y;
    full = 1'b0;
    cx   = exp_fx;
    cy   = exp_fy;
    for (int k = 0; k < MT; k++) begin
      if (!occ[cell_of(rx[k], ry[k])]) begin
        p  = k;
        cx = rx[k];
        cy = ry[k];
        return;
      end
    end
    x = rx[MT-1];
    y = ry[MT-1];
    for (int j = 1; j < 64; j++) begin
      x = x + 1;
      if (x == 8) begin
        x = 0;
        y = (y + 1) % 8;
      end
      if (!occ[cell_of(x, y)]) begin
        p  = MT - 1 + j;
        cx = x;
        cy = y;
        return;
      end
    end
    p    = MT - 1 + 63;
    full = 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic fill_rng();
    for (int k = 0; k < MT; k++) begin
      rx[k] = $urandom_range(0, 7);
      ry[k] = $urandom_range(0, 7);
    end
  endtask

  task automatic set_board(input bit v);
    for (int i = 0; i < 64; i++) occ[i] = v;
  endtask

  task automatic idle_inputs();
    bus.place_req = 1'b0;
    bus.food_clr  = 1'b0;
    bus.rng_x     = coord_t'($urandom_range(0, 7));
    bus.rng_y     = coord_t'($urandom_range(0, 7));
  endtask

  // One request. with_clr: food_clr in the request cycle; spurious:
  // place_req again in the first busy cycle; clr_busy: food_clr in that
  // busy cycle.
  task automatic place(input bit with_clr, input bit spurious,
                       input bit clr_busy);
    int p;
    int cx;
    int cy;
    bit full;
    bit got;
    int lat;
    bit v_mid;
    predict(p, cx, cy, full);
    @(posedge clk); #1;
    bus.place_req = 1'b1;
    bus.food_clr  = with_clr;
    bus.rng_x     = coord_t'(rx[0]);
    bus.rng_y     = coord_t'(ry[0]);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk); #1;
      bus.place_req = spurious && (c == 1);
      bus.food_clr  = clr_busy && (c == 1);
      if (c < MT) begin
        bus.rng_x = coord_t'(rx[c]);
        bus.rng_y = coord_t'(ry[c]);
      end else begin
        bus.rng_x = coord_t'($urandom_range(0, 7));
        bus.rng_y = coord_t'($urandom_range(0, 7));
      end
      @(negedge clk);
      if (bus.done || bus.board_full) begin
        got = 1'b1;
        lat = c;
      end else begin
        v_mid = exp_valid && !with_clr && !(clr_busy && c >= 2);
        check("busy_mid", bus.busy, 1);
        check("valid_mid", bus.food_valid, v_mid);
      end
    end
    check("result_seen", got, 1);
    if (got) begin
      check("latency", lat, p + 2);
      check("done", bus.done, !full);
      check("board_full", bus.board_full, full);
      check("food_x", bus.food_x, cx);
      check("food_y", bus.food_y, cy);
      check("food_valid", bus.food_valid, !full);
      exp_fx    = cx;
      exp_fy    = cy;
      exp_valid = !full;
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("full_one_cycle", bus.board_full, 0);
    check("idle_after", bus.busy, 0);
    check("valid_hold", bus.food_valid, exp_valid);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    set_board(1'b0);
    #2 reset = 1'b0;
    #1;
    check("rst_food_x", bus.food_x, 0);
    check("rst_food_y", bus.food_y, 0);
    check("rst_probe_x", bus.probe_x, 0);
    check("rst_probe_y", bus.probe_y, 0);
    check("rst_valid", bus.food_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_full", bus.board_full, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", bus.state_dbg, FP_IDLE);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Empty board, first sample (3,5) is free.
    set_board(1'b0);
    fill_rng();
    rx[0] = 3;
    ry[0] = 5;
    place(1'b0, 1'b0, 1'b0);

    // Three occupied samples, fourth free at (6,2).
    set_board(1'b0);
    fill_rng();
    for (int k = 0; k < 3; k++) begin
      if (rx[k] == 6 && ry[k] == 2) rx[k] = 5;
      occ[cell_of(rx[k], ry[k])] = 1'b1;
    end
    rx[3] = 6;
    ry[3] = 2;
    place(1'b0, 1'b0, 1'b0);

    // food_clr alone in IDLE: valid drops, coordinates stay.
    @(posedge clk); #1;
    bus.food_clr = 1'b1;
    @(posedge clk); #1;
    bus.food_clr = 1'b0;
    @(negedge clk);
    exp_valid = 1'b0;
    check("clr_valid", bus.food_valid, 0);
    check("clr_keep_x", bus.food_x, exp_fx);
    check("clr_keep_y", bus.food_y, exp_fy);

    // Only (0,0) free, last random sample (7,7): sweep wraps to (0,0).
    set_board(1'b1);
    occ[0] = 1'b0;
    fill_rng();
    for (int k = 0; k < MT - 1; k++) begin
      if (rx[k] == 0 && ry[k] == 0) rx[k] = 1;
    end
    rx[MT-1] = 7;
    ry[MT-1] = 7;
    place(1'b0, 1'b0, 1'b0);

    // Same-cycle clear and request, plus a request while busy.
    set_board(1'b0);
    fill_rng();
    place(1'b1, 1'b1, 1'b0);

    // Full board.
    set_board(1'b1);
    fill_rng();
    place(1'b0, 1'b0, 1'b0);

    // Food cleared while a long search is running.
    set_board(1'b0);
    fill_rng();
    place(1'b0, 1'b0, 1'b0);
    set_board(1'b1);
    occ[$urandom_range(0, 63)] = 1'b0;
    fill_rng();
    place(1'b0, 1'b0, 1'b1);

    // Random boards and samples.
    for (int it = 0; it < 20; it++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < 64; i++) occ[i] = ($urandom_range(0, 99) < dens);
      fill_rng();
      place(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the linear sweep.
    set_board(1'b1);
    fill_rng();
    @(posedge clk); #1;
    bus.place_req = 1'b1;
    bus.rng_x     = coord_t'(rx[0]);
    bus.rng_y     = coord_t'(ry[0]);
    repeat (MT + 5) begin
      @(posedge clk); #1;
      idle_inputs();
    end
    check("in_scan", bus.state_dbg, FP_SCAN);
    #1 reset = 1'b0;
    #1;
    check("arst_food_x", bus.food_x, 0);
    check("arst_food_y", bus.food_y, 0);
    check("arst_probe_x", bus.probe_x, 0);
    check("arst_probe_y", bus.probe_y, 0);
    check("arst_valid", bus.food_valid, 0);
    check("arst_done", bus.done, 0);
    check("arst_full", bus.board_full, 0);
    check("arst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_fx    = 0;
    exp_fy    = 0;
    exp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_done", bus.done, 0);
      check("post_rst_full", bus.board_full, 0);
      check("post_rst_busy", bus.busy, 0);
    end
    set_board(1'b0);
    fill_rng();
    place(1'b0, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
